// File: rtl/cop0_irq_ctrl.sv
// cop0_irq_ctrl: coprocessor-0 for the 5-stage MIPS pipeline.
// Holds STATUS/CAUSE/EPC, synchronises the external interrupt lines, picks the
// highest-priority pending exception and drives the fetch redirect and flush.
// Optional build macro: COP0_VECTORED_EN (per-cause handler vectors).
module cop0_irq_ctrl #(
    parameter int          NUM_IRQ      = 6,
    parameter int          DATA_W       = 32,
    parameter logic [31:0] HANDLER_BASE = 32'h0000_0080,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_IRQ-1:0] i_irq,
    input  logic               i_arith_overflow,
    input  logic               i_unknown_command,
    input  logic               i_unknown_func,
    input  logic [DATA_W-1:0]  i_pc_ex,
    input  logic [DATA_W-1:0]  i_pc_id,
    input  logic [DATA_W-1:0]  i_pc_if,
    input  logic               i_mtc0,
    input  logic [4:0]         i_address,
    input  logic [DATA_W-1:0]  i_data,
    input  logic               i_eret,
    output logic [DATA_W-1:0]  o_data,
    output logic               o_exception,
    output logic [DATA_W-1:0]  o_handler_address,
    output logic [DATA_W-1:0]  o_epc_to_pc,
    output logic               o_exl
);
    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;
    localparam logic [4:0] ADDR_STATUS = 5'd12;
    localparam logic [4:0] ADDR_CAUSE  = 5'd13;
    localparam logic [4:0] ADDR_EPC    = 5'd14;
    localparam logic [DATA_W-1:0] W_BASE = DATA_W'(HANDLER_BASE);

    logic [NUM_IRQ-1:0] r_sync   [SYNC_STAGES];
    logic [NUM_IRQ-1:0] w_sync_d [SYNC_STAGES];

    logic               r_ie;
    logic               r_exl;
    logic [NUM_IRQ-1:0] r_im;
    logic [4:0]         r_exc_code;
    logic [DATA_W-1:0]  r_epc;

    logic [NUM_IRQ-1:0] w_ip;
    logic [NUM_IRQ-1:0] w_pend;
    logic               w_irq_req;
    logic               w_exc;
    logic [4:0]         w_code;
    logic [DATA_W-1:0]  w_epc_hw;
    logic [DATA_W-1:0]  w_status;
    logic [DATA_W-1:0]  w_cause;

    // Synchroniser chain: stage 0 samples the pins, each later stage the previous one.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign w_sync_d[gi] = i_irq;
            end else begin : g_next
                assign w_sync_d[gi] = r_sync[gi-1];
            end
        end
    endgenerate

    // Advance the synchroniser every cycle; IP is level-sensitive, never latched.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= w_sync_d[i];
        end
    end

    assign w_ip      = r_sync[SYNC_STAGES-1];
    assign w_pend    = w_ip & r_im;
    assign w_irq_req = r_ie & ~r_exl & (|w_pend);

    // Priority resolve: overflow > illegal instruction > interrupt, all blocked by EXL.
    always_comb begin
        w_exc    = 1'b0;
        w_code   = EXC_INT;
        w_epc_hw = i_pc_if;
        if (!r_exl) begin
            if (i_arith_overflow) begin
                w_exc    = 1'b1;
                w_code   = EXC_OV;
                w_epc_hw = i_pc_ex;
            end else if (i_unknown_command || i_unknown_func) begin
                w_exc    = 1'b1;
                w_code   = EXC_RI;
                w_epc_hw = i_pc_id;
            end else if (w_irq_req) begin
                w_exc    = 1'b1;
                w_code   = EXC_INT;
                w_epc_hw = i_pc_if;
            end
        end
    end

    // Architectural state: eret, then software writes, then hardware exception entry
    // (later assignments win, so an accepted exception overrides EXL and EPC writes).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ie       <= 1'b0;
            r_exl      <= 1'b0;
            r_im       <= '0;
            r_exc_code <= 5'd0;
            r_epc      <= '0;
        end else begin
            if (i_eret) r_exl <= 1'b0;
            if (i_mtc0 && i_address == ADDR_STATUS) begin
                r_ie  <= i_data[0];
                r_exl <= i_data[1];
                r_im  <= i_data[8 +: NUM_IRQ];
            end
            if (i_mtc0 && i_address == ADDR_EPC && !w_exc) r_epc <= i_data;
            if (w_exc) begin
                r_exl      <= 1'b1;
                r_exc_code <= w_code;
                r_epc      <= w_epc_hw;
            end
        end
    end

    // mfc0 read mux; unmapped bits and indices read as zero.
    always_comb begin
        w_status              = '0;
        w_status[0]           = r_ie;
        w_status[1]           = r_exl;
        w_status[8 +: NUM_IRQ] = r_im;
        w_cause               = '0;
        w_cause[6:2]          = r_exc_code;
        w_cause[8 +: NUM_IRQ] = w_ip;
        case (i_address)
            ADDR_STATUS: o_data = w_status;
            ADDR_CAUSE:  o_data = w_cause;
            ADDR_EPC:    o_data = r_epc;
            default:     o_data = '0;
        endcase
    end

`ifdef COP0_VECTORED_EN
    logic [2:0] w_irq_idx;
    logic       w_take_irq;

    assign w_take_irq = w_exc && (w_code == EXC_INT);

    // Vector select: interrupts go to base+0x200+32*n (lowest pending n), others to base+4*ExcCode.
    always_comb begin
        w_irq_idx = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_pend[i]) w_irq_idx = 3'(i);
        end
        o_handler_address = W_BASE;
        if (w_take_irq) begin
            o_handler_address = W_BASE + DATA_W'(32'h200) + DATA_W'({w_irq_idx, 5'b0});
        end else if (w_exc) begin
            o_handler_address = W_BASE + DATA_W'({w_code, 2'b00});
        end
    end
`else
    assign o_handler_address = W_BASE;
`endif

    assign o_exception = w_exc;
    assign o_epc_to_pc = r_epc;
    assign o_exl       = r_exl;

endmodule

// File: tb/tb_cop0_irq_ctrl.sv
// tb_cop0_irq_ctrl: directed stimulus with a rule-level model compared every cycle,
// plus literal expectations at key points.
module tb_cop0_irq_ctrl;
    localparam int          NI   = 6;
    localparam int          DW   = 32;
    localparam int          SS   = 2;
    localparam logic [31:0] BASE = 32'h0000_0080;

`ifdef COP0_VECTORED_EN
    localparam logic [31:0] HA_IRQ0 = 32'h280;
    localparam logic [31:0] HA_OV   = 32'hB0;
    localparam logic [31:0] HA_RI   = 32'hA8;
    localparam logic [31:0] HA_IRQ3 = 32'h2E0;
`else
    localparam logic [31:0] HA_IRQ0 = 32'h80;
    localparam logic [31:0] HA_OV   = 32'h80;
    localparam logic [31:0] HA_RI   = 32'h80;
    localparam logic [31:0] HA_IRQ3 = 32'h80;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NI-1:0] i_irq = '0;
    logic          i_arith_overflow = 1'b0;
    logic          i_unknown_command = 1'b0;
    logic          i_unknown_func = 1'b0;
    logic [DW-1:0] i_pc_ex = '0;
    logic [DW-1:0] i_pc_id = '0;
    logic [DW-1:0] i_pc_if = '0;
    logic          i_mtc0 = 1'b0;
    logic [4:0]    i_address = 5'd12;
    logic [DW-1:0] i_data = '0;
    logic          i_eret = 1'b0;
    logic [DW-1:0] o_data;
    logic          o_exception;
    logic [DW-1:0] o_handler_address;
    logic [DW-1:0] o_epc_to_pc;
    logic          o_exl;

    always #5 clk = ~clk;

    cop0_irq_ctrl #(
        .NUM_IRQ(NI), .DATA_W(DW), .HANDLER_BASE(BASE), .SYNC_STAGES(SS)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_irq(i_irq),
        .i_arith_overflow(i_arith_overflow), .i_unknown_command(i_unknown_command),
        .i_unknown_func(i_unknown_func), .i_pc_ex(i_pc_ex), .i_pc_id(i_pc_id),
        .i_pc_if(i_pc_if), .i_mtc0(i_mtc0), .i_address(i_address), .i_data(i_data),
        .i_eret(i_eret), .o_data(o_data), .o_exception(o_exception),
        .o_handler_address(o_handler_address), .o_epc_to_pc(o_epc_to_pc), .o_exl(o_exl)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // hist[0] is the newest sample of the pins; hist[SS-1] is what software sees as IP.
    typedef struct packed {
        logic               ie;
        logic               exl;
        logic [NI-1:0]      im;
        logic [4:0]         code;
        logic [31:0]        epc;
        logic [SS-1:0][NI-1:0] hist;
    } mstate_t;

    mstate_t m = '0;

    function automatic logic [NI-1:0] pending(input mstate_t s);
        return s.hist[SS-1] & s.im;
    endfunction

    // Which exception (if any) the rules say is taken this cycle.
    function automatic int cause_of(input mstate_t s);
        if (s.exl) return -1;
        if (i_arith_overflow) return 12;
        if (i_unknown_command || i_unknown_func) return 10;
        if (s.ie && pending(s) != '0) return 0;
        return -1;
    endfunction

    function automatic logic [31:0] victim_pc(input int c);
        if (c == 12) return i_pc_ex;
        if (c == 10) return i_pc_id;
        return i_pc_if;
    endfunction

    function automatic logic [31:0] exp_handler(input mstate_t s);
`ifdef COP0_VECTORED_EN
        int c = cause_of(s);
        logic [NI-1:0] p = pending(s);
        int lowest = -1;
        if (c < 0) return BASE;
        if (c > 0) return BASE + 32'(c) * 4;
        for (int k = 0; k < NI; k++) if (lowest < 0 && p[k]) lowest = k;
        return BASE + 32'h200 + 32'(lowest) * 32;
`else
        return BASE + 32'(0 * cause_of(s));
`endif
    endfunction

    function automatic logic [31:0] exp_data(input mstate_t s);
        case (i_address)
            5'd12: return 32'(s.ie) + 32'(s.exl) * 2 + (32'(s.im) << 8);
            5'd13: return (32'(s.hist[SS-1]) << 8) + (32'(s.code) << 2);
            5'd14: return s.epc;
            default: return 32'h0;
        endcase
    endfunction

    function automatic mstate_t step(input mstate_t s);
        mstate_t n = s;
        int c = cause_of(s);
        if (i_eret) n.exl = 1'b0;
        if (i_mtc0 && i_address == 5'd12) begin
            n.ie  = i_data[0];
            n.exl = i_data[1];
            n.im  = i_data[8 +: NI];
        end
        if (i_mtc0 && i_address == 5'd14 && c < 0) n.epc = i_data;
        if (c >= 0) begin
            n.exl  = 1'b1;
            n.code = 5'(c);
            n.epc  = victim_pc(c);
        end
        for (int k = SS - 1; k > 0; k--) n.hist[k] = s.hist[k-1];
        n.hist[0] = i_irq;
        return n;
    endfunction

    // Model state update, including the asynchronous reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= step(m);
    end

    // Per-cycle comparison of all outputs against the model, away from the active edge.
    always @(negedge clk) begin
        chk("cyc_exception", 32'(o_exception), (cause_of(m) >= 0) ? 32'd1 : 32'd0);
        chk("cyc_handler", o_handler_address, exp_handler(m));
        chk("cyc_epc_to_pc", o_epc_to_pc, m.epc);
        chk("cyc_exl", 32'(o_exl), 32'(m.exl));
        chk("cyc_data", o_data, exp_data(m));
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        // reset state
        i_address = 5'd12; #1;
        chk("rst_status", o_data, 32'h0);
        chk("rst_exl", 32'(o_exl), 32'h0);
        chk("rst_handler", o_handler_address, 32'h80);
        chk("rst_epc_to_pc", o_epc_to_pc, 32'h0);
        rst_n = 1'b1;
        tick();
        i_address = 5'd13; #1; chk("rd_cause0", o_data, 32'h0);
        i_address = 5'd14; #1; chk("rd_epc0", o_data, 32'h0);
        chk("idle_exc", 32'(o_exception), 32'h0);

        // IE=1, IM0=1, then raise irq0: pulse after exactly SYNC_STAGES edges
        i_mtc0 = 1'b1; i_address = 5'd12; i_data = 32'h101;
        tick();
        i_mtc0 = 1'b0; #1;
        chk("status_rd", o_data, 32'h101);
        i_pc_if = 32'h40; i_irq = 6'b000001;
        tick(); chk("irq_lat1", 32'(o_exception), 32'h0);
        tick(); chk("irq_lat2", 32'(o_exception), 32'h1);
        chk("irq0_handler", o_handler_address, HA_IRQ0);
        tick(); chk("irq_pulse_end", 32'(o_exception), 32'h0);
        chk("irq_exl", 32'(o_exl), 32'h1);
        i_address = 5'd14; #1; chk("irq_epc", o_data, 32'h40);
        i_address = 5'd13; #1; chk("irq_cause", o_data, 32'h100);

        // EXL blocks a synchronous source; EPC untouched
        i_unknown_func = 1'b1; i_pc_id = 32'h300; #1;
        chk("exl_blocks", 32'(o_exception), 32'h0);
        tick();
        i_unknown_func = 1'b0; i_address = 5'd14; #1;
        chk("exl_epc_kept", o_data, 32'h40);

        // eret with irq still pending: it fires once EXL is clear
        i_eret = 1'b1; #1;
        chk("eret_epc", o_epc_to_pc, 32'h40);
        chk("eret_cycle_exc", 32'(o_exception), 32'h0);
        tick();
        i_eret = 1'b0; i_pc_if = 32'h44; #1;
        chk("eret_exl", 32'(o_exl), 32'h0);
        chk("irq_after_eret", 32'(o_exception), 32'h1);
        tick();
        chk("irq2_exl", 32'(o_exl), 32'h1);
        chk("irq2_epc", o_epc_to_pc, 32'h44);

        // overflow + unknown_command + pending irq, first offered alongside eret
        i_arith_overflow = 1'b1; i_pc_ex = 32'h100;
        i_unknown_command = 1'b1; i_pc_id = 32'h104; i_eret = 1'b1; #1;
        chk("eret_ignores_src", 32'(o_exception), 32'h0);
        tick();
        i_eret = 1'b0; #1;
        chk("ovf_taken", 32'(o_exception), 32'h1);
        chk("ovf_handler", o_handler_address, HA_OV);
        tick();
        i_arith_overflow = 1'b0; i_unknown_command = 1'b0; #1;
        chk("ovf_pulse_end", 32'(o_exception), 32'h0);
        i_address = 5'd14; #1; chk("ovf_epc", o_data, 32'h100);
        i_address = 5'd13; #1; chk("ovf_cause", o_data, 32'h130);

        // drain the irq, leave the handler
        i_irq = '0;
        tick(); tick();
        i_eret = 1'b1;
        tick();
        i_eret = 1'b0; #1;
        chk("drained_exc", 32'(o_exception), 32'h0);
        chk("drained_exl", 32'(o_exl), 32'h0);

        // mtc0 EPC colliding with an overflow: hardware wins
        i_mtc0 = 1'b1; i_address = 5'd14; i_data = 32'hDEAD;
        i_arith_overflow = 1'b1; i_pc_ex = 32'h200; #1;
        chk("ovf2_taken", 32'(o_exception), 32'h1);
        tick();
        i_mtc0 = 1'b0; i_arith_overflow = 1'b0; #1;
        chk("epc_hw_wins", o_data, 32'h200);
        i_mtc0 = 1'b1; i_data = 32'h1234;
        tick();
        i_mtc0 = 1'b0; #1;
        chk("epc_sw_write", o_data, 32'h1234);

        // STATUS=3 written together with an illegal-funct exception
        i_eret = 1'b1;
        tick();
        i_eret = 1'b0;
        i_mtc0 = 1'b1; i_address = 5'd12; i_data = 32'h3;
        i_unknown_func = 1'b1; i_pc_id = 32'h208; #1;
        chk("ri_taken", 32'(o_exception), 32'h1);
        chk("ri_handler", o_handler_address, HA_RI);
        tick();
        i_mtc0 = 1'b0; i_unknown_func = 1'b0; #1;
        chk("status_forced", o_data, 32'h3);
        i_address = 5'd14; #1; chk("ri_epc", o_data, 32'h208);
        i_address = 5'd13; #1; chk("ri_cause", o_data, 32'h28);

        // masked irq3 visible in IP, taken the cycle after IM3 is set
        i_mtc0 = 1'b1; i_address = 5'd12; i_data = 32'h1;
        tick();
        i_mtc0 = 1'b0; i_irq = 6'b001000; i_pc_if = 32'h500;
        tick(); tick();
        i_address = 5'd13; #1;
        chk("ip3_visible", o_data, 32'h828);
        chk("ip3_masked", 32'(o_exception), 32'h0);
        i_mtc0 = 1'b1; i_address = 5'd12; i_data = 32'h801; #1;
        chk("im3_same_cycle", 32'(o_exception), 32'h0);
        tick();
        i_mtc0 = 1'b0; #1;
        chk("im3_taken", 32'(o_exception), 32'h1);
        chk("irq3_handler", o_handler_address, HA_IRQ3);
        tick();
        chk("irq3_epc", o_epc_to_pc, 32'h500);
        chk("irq3_exl", 32'(o_exl), 32'h1);

        // reset in the middle of the handler
        tick();
        rst_n = 1'b0; #1;
        chk("midrst_exl", 32'(o_exl), 32'h0);
        i_address = 5'd12; #1; chk("midrst_status", o_data, 32'h0);
        i_address = 5'd13; #1; chk("midrst_cause", o_data, 32'h0);
        chk("midrst_handler", o_handler_address, 32'h80);
        i_irq = '0;
        tick();
        rst_n = 1'b1;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cop0_irq_ctrl.md
Name: cop0_irq_ctrl

Overview:
Parametrised coprocessor-0 for the 5-stage MIPS pipeline. Handles NUM_IRQ maskable external interrupt lines and three synchronous exception sources, with priority resolution. Holds STATUS, CAUSE and EPC, and serves mtc0/mfc0/eret. Drives the fetch redirect (handler address, EPC) and the pipeline flush strobe.

Parameters:
NUM_IRQ, 6, number of external interrupt lines (1..8)
DATA_W, 32, register/PC width
HANDLER_BASE, 32'h0000_0080, exception entry address
SYNC_STAGES, 2, synchroniser depth on i_irq (>=1)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_irq  in  NUM_IRQ  external interrupt levels, asynchronous to i_clk
i_arith_overflow  in  1  overflow in execute stage
i_unknown_command  in  1  illegal opcode in decode
i_unknown_func  in  1  illegal funct in decode
i_pc_ex  in  DATA_W  PC of the execute-stage instruction
i_pc_id  in  DATA_W  PC of the decode-stage instruction
i_pc_if  in  DATA_W  PC of the fetch-stage instruction
i_mtc0  in  1  write strobe
i_address  in  5  cop0 register index (rd field)
i_data  in  DATA_W  mtc0 write data
i_eret  in  1  return from exception
o_data  out  DATA_W  mfc0 read data (combinational)
o_exception  out  1  flush/redirect strobe (combinational)
o_handler_address  out  DATA_W  fetch target when o_exception=1
o_epc_to_pc  out  DATA_W  current EPC, fetch target on eret
o_exl  out  1  handler-active flag

Behaviour:
- Register map:
  - reg12 STATUS: [0] IE, [1] EXL, [8+NUM_IRQ-1:8] IM; other bits read 0.
  - reg13 CAUSE: [6:2] ExcCode, [8+NUM_IRQ-1:8] IP; read-only, mtc0 ignored.
  - reg14 EPC: read/write.
  - Unmapped indices read 0; writes to them are dropped.
- Reset (async): STATUS=0, CAUSE.ExcCode=0, EPC=0, all synchroniser flops=0. Outputs: o_exception=0, o_exl=0, o_data=0 for index 12, o_handler_address=HANDLER_BASE, o_epc_to_pc=0.
- IP = i_irq after SYNC_STAGES flops. Level-sensitive, updated every cycle, not latched.
- irq_req = IE & !EXL & |(IP & IM).
- Priority, highest first, evaluated only when EXL=0:
  1. overflow: ExcCode 12, EPC<=i_pc_ex.
  2. unknown_command or unknown_func: ExcCode 10, EPC<=i_pc_id.
  3. irq_req: ExcCode 0, EPC<=i_pc_if.
- Exception accepted:
  - o_exception=1 in the same cycle (zero latency).
  - At the next edge: EPC and ExcCode are written and EXL<=1.
  - o_exception is therefore a single-cycle pulse.
- When EXL=1, all exception sources are ignored; CAUSE and EPC are not modified. IP still tracks the irq lines.
- eret: EXL<=0 at the next edge. o_epc_to_pc is valid continuously.
- eret in the same cycle as an exception source while EXL=1: the source is ignored and eret completes. The earliest interrupt is taken the cycle after EXL clears.
- mtc0 in the same cycle as an accepted exception:
  - Hardware updates of EPC, ExcCode and EXL win.
  - A STATUS write still updates IE and IM, but EXL is forced to 1.
  - An EPC write is dropped.
- mtc0 to STATUS may set or clear EXL directly.
- Interrupt latency from an i_irq rising edge to o_exception: SYNC_STAGES cycles, given IE=1, IM bit=1, EXL=0.
- Reset asserted mid-handler clears EXL immediately; the pipeline restarts from its reset PC.

Optional Feature:
COP0_VECTORED_EN
- Defined: o_handler_address = HANDLER_BASE + 32'h200 + (n<<5) for an interrupt, where n is the lowest-index active (IP & IM) bit. Synchronous exceptions use HANDLER_BASE + (ExcCode<<2).
- Undefined: o_handler_address = HANDLER_BASE for every cause.

Test Plan:
- Reset, then mfc0 reads of reg12/13/14 -> all 0; o_exception=0; o_handler_address=0x80.
- mtc0 STATUS=0x0000_0101 (IE=1, IM0=1); raise i_irq[0]; i_pc_if=0x40 -> o_exception pulses exactly SYNC_STAGES cycles after the rise, for one cycle. Then EPC=0x40, ExcCode=0, o_exl=1. With COP0_VECTORED_EN defined, o_handler_address=0x280.
- Overflow with i_pc_ex=0x100 and unknown_command with i_pc_id=0x104 in the same cycle, irq also pending -> EPC=0x100, ExcCode=12, a single pulse.
- EXL=1, pulse unknown_func -> o_exception stays 0 and EPC is unchanged. Assert i_eret -> o_epc_to_pc equals EPC; EXL=0 next cycle. A still-pending irq fires the following cycle.
- mtc0 EPC=0xDEAD in the same cycle as an overflow with i_pc_ex=0x200 -> EPC=0x200. mtc0 STATUS=0x3 in the same cycle as an exception -> IE=1, EXL=1.
- i_irq[3] raised with IM3=0 -> CAUSE.IP[3]=1 after SYNC_STAGES cycles, no exception. Set IM3=1 via mtc0 -> exception on the next cycle.
